// File: rtl/message_scheduler.sv
// SHA-256 message schedule generator: streams W[0..63] for one 512-bit block, one word per accepted en.
// Optional macro SCHED_KROM_EN adds the SHA-256 K table and drives k = K[round] alongside w.
module message_scheduler (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block,
  input  logic         en,
  output logic [31:0]  w,
  output logic [31:0]  k,
  output logic         w_valid,
  output logic [5:0]   round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  round_q, round_d;
  logic [31:0] w_q, w_d;
  logic        w_valid_q, w_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] next_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign next_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    w_d       = w_q;
    w_valid_d = w_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < 16; i++) win_d[i] = block[511 - 32*i -: 32];
          round_d   = 6'd0;
          w_d       = block[511:480];
          w_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (en) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
          win_d[15] = next_word;
          // The last word leaves w and round parked; consumers rely on w_valid dropping.
          if (round_q == 6'd63) begin
            w_valid_d = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
          end else begin
            round_d = round_q + 6'd1;
            w_d     = win_q[1];
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        w_valid_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      round_q   <= 6'd0;
      w_q       <= 32'h0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'h0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

`ifdef SCHED_KROM_EN
  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] k_q, k_d;

  // k only moves when w moves, so the pair always describes the same round.
  always_comb begin
    k_d = k_q;
    if (state_q == IDLE && start)
      k_d = K_TABLE[6'd0];
    else if (state_q == RUN && en && round_q != 6'd63)
      k_d = K_TABLE[round_q + 6'd1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) k_q <= 32'h0;
    else        k_q <= k_d;
  end

  assign k = k_q;
`else
  assign k = 32'h0;
`endif

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign round   = round_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_message_scheduler.sv
// Scoreboard bench for message_scheduler: a reference expansion of the block feeds a queue that a
// negedge monitor drains whenever a word is consumed (w_valid && en); done pulses are checked by cycle.
module tb_message_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block = '0;
  logic         en = 1'b0;
  logic [31:0]  w, k;
  logic         w_valid, busy, done;
  logic [5:0]   round;

  message_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block(block), .en(en),
    .w(w), .k(k), .w_valid(w_valid), .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  r;
  } item_t;

  item_t       exp_q[$];
  int          exp_done[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_w [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic expand(input logic [511:0] b);
    for (int t = 0; t < 16; t++) model_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      model_w[t] = s1(model_w[t-2]) + model_w[t-7] + s0(model_w[t-15]) + model_w[t-16];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: one line per consumed word, compared against the scoreboard front
  always @(negedge clk) begin
    item_t it;
    if (rst_n && w_valid && en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got w=%h round=%0d expected no word", w, round);
      end else begin
        it = exp_q.pop_front();
        $display("[TB] word round=%0d w=%h k=%h", round, w, k);
        chk("w", w, it.w);
        chk("round", {26'b0, round}, {26'b0, it.r});
`ifdef SCHED_KROM_EN
        if (it.r == 6'd0)  chk("k_round0", k, 32'h428a2f98);
        if (it.r == 6'd63) chk("k_round63", k, 32'hc67178f2);
`else
        chk("k_zero", k, 32'h0);
`endif
      end
    end
    if (rst_n && done) begin
      if (exp_done.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        chk("done_cycle", cyc, exp_done.pop_front());
        chk("done_wvalid", {31'b0, w_valid}, 32'h0);
        $display("[TB] done at cycle %0d", cyc);
      end
    end
  end

  task automatic run_block(input logic [511:0] blk, input bit rand_en,
                           input int restart_at, input int reset_at);
    int   consumed = 0;
    int   guard = 0;
    item_t it;
    expand(blk);
    for (int t = 0; t < 64; t++) begin
      it.w = model_w[t];
      it.r = 6'(t);
      exp_q.push_back(it);
    end
    block = blk;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    block = rand_block();
    chk("first_valid", {31'b0, w_valid}, 32'h1);
    chk("busy_run", {31'b0, busy}, 32'h1);
    while (consumed < 64 && guard < 2000) begin
      guard++;
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (consumed == restart_at) begin
        start = 1'b1;
        block = ~blk;
      end
      if (consumed == reset_at) rst_n = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (!rst_n) begin
        rst_n = 1'b1;
        en = 1'b0;
        exp_q.delete();
        chk("rst_wvalid", {31'b0, w_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_round", {26'b0, round}, 32'h0);
        chk("rst_w", w, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        return;
      end
      if (en) begin
        consumed++;
        if (consumed == 64) exp_done.push_back(cyc);
      end
    end
    if (guard >= 2000) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got %0d words expected 64", consumed);
    end
    en = 1'b0;
    @(posedge clk); #1;
    chk("done_seen", exp_done.size(), 32'h0);
    chk("w_hold", w, model_w[63]);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("idle_done", {31'b0, done}, 32'h0);
    chk("idle_wvalid", {31'b0, w_valid}, 32'h0);
    chk("words_left", exp_q.size(), 32'h0);
    exp_done.delete();
  endtask

  initial begin
    logic [511:0] abc;
    abc = {32'h61626380, 448'b0, 32'h00000018};

    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_w", w, 32'h0);
    chk("reset_k", k, 32'h0);
    chk("reset_wvalid", {31'b0, w_valid}, 32'h0);
    chk("reset_round", {26'b0, round}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(abc, 1'b0, -1, -1);
    run_block(abc, 1'b1, -1, -1);
    run_block(rand_block(), 1'b1, -1, -1);
    run_block(rand_block(), 1'b0, -1, -1);
    run_block(abc, 1'b0, 20, -1);
    run_block(rand_block(), 1'b1, 20, -1);
    run_block(rand_block(), 1'b1, -1, 30);
    run_block(abc, 1'b0, -1, -1);

    // start coinciding with reset must not launch a block
    rst_n = 1'b0;
    start = 1'b1;
    block = rand_block();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    chk("rst_start_busy", {31'b0, busy}, 32'h0);
    chk("rst_start_wvalid", {31'b0, w_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rst_start_busy2", {31'b0, busy}, 32'h0);
    run_block(rand_block(), 1'b1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    tests++;
    fails++;
    $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
